sequence_counter: RTL and testbench



---
 rtl/sequence_counter.sv | 43 ++++
 tb/tb_sequence_counter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/sequence_counter.sv
// Sequence counter for the basic-computer control unit: a binary state count with a
// one-hot T decode used by the controller to sequence fetch and execute micro-operations.
module sequence_counter #(
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      CLR,
  input  logic                      INR,
  output logic [2**CNT_WIDTH-1:0]   T,
  output logic [CNT_WIDTH-1:0]      SC_VAL
);

  localparam int unsigned NumT = 2**CNT_WIDTH;

  logic [CNT_WIDTH-1:0] count_q, count_d;

  // Clear beats increment; increment wraps naturally at the register width.
  always_comb begin
    count_d = count_q;
    if (CLR) begin
      count_d = '0;
    end else if (INR) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Unregistered decode so T tracks the count in the same cycle, including during reset.
  always_comb begin
    T = NumT'(1) << count_q;
  end

  assign SC_VAL = count_q;

endmodule

// File: tb/tb_sequence_counter.sv
// Randomized self-checking bench for sequence_counter against an arithmetic reference
// model of the count (mod 16) and its expected one-hot timing signal.
module tb_sequence_counter;

  logic        clk;
  logic        rst_n;
  logic        CLR;
  logic        INR;
  logic [15:0] T;
  logic [3:0]  SC_VAL;

  int model_cnt;
  int n_checks;
  int n_pass;

  sequence_counter #(
    .CNT_WIDTH (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .CLR    (CLR),
    .INR    (INR),
    .T      (T),
    .SC_VAL (SC_VAL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Compare both outputs against the model count.
  task automatic check_state(input string tag);
    logic [15:0] exp_t;
    exp_t = 16'd1 << model_cnt;
    check_val({tag, "_T"}, {16'd0, T}, {16'd0, exp_t});
    check_val({tag, "_SC"}, {28'd0, SC_VAL}, model_cnt);
  endtask

  // Drive one cycle of inputs just after an edge, then check just after the next edge.
  task automatic step(input string tag, input logic inr, input logic clr, input logic rstn);
    INR   = inr;
    CLR   = clr;
    rst_n = rstn;
    if (!rstn) begin
      model_cnt = 0;
      #1;
      check_state({tag, "_async"});
    end
    @(posedge clk);
    if (rstn) begin
      if (clr)      model_cnt = 0;
      else if (inr) model_cnt = (model_cnt + 1) % 16;
    end
    #1;
    check_state(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    model_cnt = 0;
    rst_n     = 1'b0;
    INR       = 1'b0;
    CLR       = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_state("reset");

    // Release with idle inputs: count must stay at 0.
    step("release", 1'b0, 1'b0, 1'b1);
    step("release_hold", 1'b0, 1'b0, 1'b1);

    // Increment walk through all 16 values and the wrap back to T0.
    for (int i = 0; i < 16; i++) step("walk", 1'b1, 1'b0, 1'b1);
    check_val("walk_wrap", {16'd0, T}, 32'h0001);

    // Hold at 3.
    for (int i = 0; i < 3; i++) step("fetch", 1'b1, 1'b0, 1'b1);
    check_val("fetch_t3", {16'd0, T}, 32'h0008);
    for (int i = 0; i < 4; i++) step("hold", 1'b0, 1'b0, 1'b1);
    check_val("hold_t3", {16'd0, T}, 32'h0008);

    // Clear from 3.
    step("clear", 1'b0, 1'b1, 1'b1);
    check_val("clear_t0", {16'd0, T}, 32'h0001);

    // Priority at 2: CLR wins over INR.
    step("pri_a", 1'b1, 1'b0, 1'b1);
    step("pri_b", 1'b1, 1'b0, 1'b1);
    step("priority", 1'b1, 1'b1, 1'b1);
    check_val("priority_sc", {28'd0, SC_VAL}, 32'd0);

    // Asynchronous reset mid-cycle at count 5, held across an edge with INR high.
    for (int i = 0; i < 5; i++) step("to5", 1'b1, 1'b0, 1'b1);
    check_val("at5_sc", {28'd0, SC_VAL}, 32'd5);
    step("rst_mid", 1'b1, 1'b1, 1'b0);
    step("rst_held", 1'b1, 1'b0, 1'b0);
    step("rst_release", 1'b0, 1'b0, 1'b1);

    // Random INR/CLR with occasional reset.
    for (int i = 0; i < 1000; i++) begin
      logic r_inr, r_clr, r_rstn;
      r_inr  = $urandom_range(0, 3) != 0;
      r_clr  = $urandom_range(0, 7) == 0;
      r_rstn = $urandom_range(0, 31) != 0;
      step("rand", r_inr, r_clr, r_rstn);
      check_val("rand_onehot", {31'd0, $onehot(T)}, 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
